// File: rtl/network_core.sv
// network_core: fixed-weight 9-3-1 fully-connected classifier, Q16.16 signed.
// One multiply-accumulate per clock; 34 clocks from the accepting start edge
// to a valid decision.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   input_0..input_8  signed Q16.16 features, latched on the accepting edge
//   start             level; a rising edge in IDLE or DONE starts a computation
//   out_2             decision, 1 when the output score is strictly positive
//   end_2             result valid; held in DONE until the next start edge
module network_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 16,
    // entry j*9+i sits at bits [(j*9+i)*WIDTH +: WIDTH]
    parameter logic [27*WIDTH-1:0] W1 = {{4{32'h0000_0000}}, 32'h0001_0000, {4{32'h0000_0000}},
                                         {9{32'hFFFF_0000}},
                                         {9{32'h0001_0000}}},
    parameter logic [3*WIDTH-1:0]  B1 = '0,
    parameter logic [3*WIDTH-1:0]  W2 = {32'hFFFE_0000, 32'h0001_0000, 32'h0001_0000},
    parameter logic [WIDTH-1:0]    B2 = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_0,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic [WIDTH-1:0] input_3,
    input  logic [WIDTH-1:0] input_4,
    input  logic [WIDTH-1:0] input_5,
    input  logic [WIDTH-1:0] input_6,
    input  logic [WIDTH-1:0] input_7,
    input  logic [WIDTH-1:0] input_8,
    input  logic             start,
    output logic             out_2,
    output logic             end_2
);

    typedef enum logic [2:0] {IDLE, L1_MAC, L1_ACT, L2_MAC, L2_ACT, DONE} state_t;

    localparam logic signed [2*WIDTH-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t state, state_next;

    logic                      start_d;
    logic [WIDTH-1:0]          x [9];
    logic [WIDTH-1:0]          h [3];
    logic signed [2*WIDTH-1:0] acc;
    logic [3:0]                i;
    logic [1:0]                j;
    logic [1:0]                k;

    logic [WIDTH-1:0] w1_arr [27];
    logic [WIDTH-1:0] b1_arr [3];
    logic [WIDTH-1:0] w2_arr [3];

    for (genvar n = 0; n < 27; n++) begin : g_w1
        assign w1_arr[n] = W1[n*WIDTH +: WIDTH];
    end
    for (genvar n = 0; n < 3; n++) begin : g_l2
        assign b1_arr[n] = B1[n*WIDTH +: WIDTH];
        assign w2_arr[n] = W2[n*WIDTH +: WIDTH];
    end

    function automatic logic [WIDTH-1:0] sat(input logic signed [2*WIDTH-1:0] v);
        if (v > SAT_MAX)
            return {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < SAT_MIN)
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return v[WIDTH-1:0];
    endfunction

    logic                      start_fire;
    logic [4:0]                widx;
    logic [WIDTH-1:0]          mac_a, mac_w;
    logic signed [2*WIDTH-1:0] prod, term;
    logic signed [2*WIDTH-1:0] s1, s2;
    logic [WIDTH-1:0]          h_val, score;

    assign start_fire = start && !start_d && (state == IDLE || state == DONE);
    assign widx       = 5'(j) * 5'd9 + 5'(i);

    // Single shared multiplier: layer-2 operands only in L2_MAC.
    always_comb begin
        mac_a = x[i];
        mac_w = w1_arr[widx];
        if (state == L2_MAC) begin
            mac_a = h[k];
            mac_w = w2_arr[k];
        end
        prod  = $signed({{WIDTH{mac_a[WIDTH-1]}}, mac_a}) * $signed({{WIDTH{mac_w[WIDTH-1]}}, mac_w});
        term  = prod >>> FRAC;
        s1    = acc + $signed({{WIDTH{b1_arr[j][WIDTH-1]}}, b1_arr[j]});
        s2    = acc + $signed({{WIDTH{B2[WIDTH-1]}}, B2});
        h_val = sat(s1);
        if (h_val[WIDTH-1])
            h_val = '0;
        score = sat(s2);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start_fire) state_next = L1_MAC;
            L1_MAC:     if (i == 4'd8) state_next = L1_ACT;
            L1_ACT:     state_next = (j < 2'd2) ? L1_MAC : L2_MAC;
            L2_MAC:     if (k == 2'd2) state_next = L2_ACT;
            L2_ACT:     state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d <= 1'b0;
            out_2   <= 1'b0;
            end_2   <= 1'b0;
            acc     <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            for (int unsigned n = 0; n < 9; n++) x[n] <= '0;
            for (int unsigned n = 0; n < 3; n++) h[n] <= '0;
        end else begin
            start_d <= start;
            case (state)
                IDLE, DONE: begin
                    if (start_fire) begin
                        x[0]  <= input_0;
                        x[1]  <= input_1;
                        x[2]  <= input_2;
                        x[3]  <= input_3;
                        x[4]  <= input_4;
                        x[5]  <= input_5;
                        x[6]  <= input_6;
                        x[7]  <= input_7;
                        x[8]  <= input_8;
                        end_2 <= 1'b0;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                    end
                end
                L1_MAC: begin
                    acc <= acc + term;
                    i   <= (i == 4'd8) ? 4'd0 : i + 4'd1;
                end
                L1_ACT: begin
                    h[j] <= h_val;
                    acc  <= '0;
                    i    <= '0;
                    k    <= '0;
                    if (j < 2'd2)
                        j <= j + 2'd1;
                end
                L2_MAC: begin
                    acc <= acc + term;
                    k   <= (k == 2'd2) ? 2'd0 : k + 2'd1;
                end
                L2_ACT: begin
                    out_2 <= ($signed(score) > 0);
                    end_2 <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_network_core.sv
module tb_network_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] in_v [9];
    logic        out_2;
    logic        end_2;

    int errors;
    int checks;
    logic last_out;

    network_core dut (
        .clk     (clk),
        .rst     (rst),
        .input_0 (in_v[0]),
        .input_1 (in_v[1]),
        .input_2 (in_v[2]),
        .input_3 (in_v[3]),
        .input_4 (in_v[4]),
        .input_5 (in_v[5]),
        .input_6 (in_v[6]),
        .input_7 (in_v[7]),
        .input_8 (in_v[8]),
        .start   (start),
        .out_2   (out_2),
        .end_2   (end_2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] x [9];
        logic        exp_out;
    } vec_t;

    localparam int NVEC = 11;
    vec_t tab [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input int v);
        for (int n = 0; n < 9; n++) in_v[n] = tab[v].x[n];
    endtask

    task automatic set_all(input logic [31:0] val);
        for (int n = 0; n < 9; n++) in_v[n] = val;
    endtask

    // Waits for end_2 after the accepting edge; returns edge count or 0 on timeout.
    task automatic wait_done(input int first_edge, output int lat);
        lat = 0;
        for (int n = first_edge; n <= 60; n++) begin
            @(posedge clk); #1;
            if (end_2) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_vec(input int v);
        int lat;
        set_inputs(v);
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;          // accepting edge (cycle 0)
        check($sformatf("v%0d end_cleared", v), 32'(end_2), 32'd0);
        check($sformatf("v%0d out_kept", v), 32'(out_2), 32'(last_out));
        set_all(32'h0);              // inputs are latched; changes must not matter
        wait_done(1, lat);
        check($sformatf("v%0d latency", v), lat, 34);
        check($sformatf("v%0d out_2", v), 32'(out_2), 32'(tab[v].exp_out));
        repeat (5) @(posedge clk);   // start still high: no retrigger
        #1;
        check($sformatf("v%0d hold_end", v), 32'(end_2), 32'd1);
        check($sformatf("v%0d hold_out", v), 32'(out_2), 32'(tab[v].exp_out));
        last_out = tab[v].exp_out;
        start = 1'b0;
    endtask

    initial begin
        int lat;
        logic idle_ok;
        errors   = 0;
        checks   = 0;
        last_out = 1'b0;
        start    = 1'b0;
        set_all(32'h0);

        for (int v = 0; v < NVEC; v++)
            for (int n = 0; n < 9; n++) tab[v].x[n] = 32'h0;
        // Default weights: h0 = sum x, h1 = relu(-sum x), h2 = relu(x4), score = h0 + h1 - 2*h2
        for (int n = 0; n < 9; n++) tab[0].x[n] = 32'h0001_0000;  // h=(9,0,1) score 7
        tab[0].exp_out = 1'b1;
        tab[1].x[4] = 32'h0001_0000;                               // h=(1,0,1) score -1
        tab[1].exp_out = 1'b0;
        for (int n = 0; n < 9; n++) tab[2].x[n] = 32'hFFFF_0000;  // h=(0,9,0) score 9
        tab[2].exp_out = 1'b1;
        tab[3].exp_out = 1'b0;                                     // score 0, strict compare
        // h0 saturates to 0x7FFFFFFF, h2 = 32767.0, score ~ 32768 - 65534 < 0
        for (int n = 0; n < 9; n++) tab[4].x[n] = 32'h7FFF_0000;
        tab[4].exp_out = 1'b0;
        // Without input_4: h0 saturates (wrapped it would be -8.0 -> 0), h2=0, score>0
        for (int n = 0; n < 9; n++) tab[5].x[n] = 32'h7FFF_0000;
        tab[5].x[4] = 32'h0;
        tab[5].exp_out = 1'b1;
        tab[6].x[0] = 32'h0002_0000; tab[6].x[4] = 32'h0001_0000;  // 3 - 2 = 1
        tab[6].exp_out = 1'b1;
        tab[7].x[0] = 32'h0001_0000; tab[7].x[4] = 32'h0002_0000;  // 3 - 4 = -1
        tab[7].exp_out = 1'b0;
        tab[8].x[0] = 32'h0000_4000; tab[8].x[4] = 32'h0000_8000;  // 0.75 - 1.0
        tab[8].exp_out = 1'b0;
        tab[9].x[0] = 32'h0000_0001;                               // +1 ulp score
        tab[9].exp_out = 1'b1;
        tab[10].x[0] = 32'hFFFF_FFFF;                              // h1 = +1 ulp
        tab[10].exp_out = 1'b1;

        // Asynchronous reset with no clock edge yet.
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset out_2", 32'(out_2), 32'd0);
        check("reset end_2", 32'(end_2), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_ok = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
            if (out_2 !== 1'b0 || end_2 !== 1'b0) idle_ok = 1'b0;
        end
        check("idle_50_cycles", 32'(idle_ok), 32'd1);

        for (int v = 0; v < NVEC; v++) run_vec(v);

        // Asynchronous reset clears a held result between edges.
        run_vec(0);
        #2 rst = 1'b1;
        #1;
        check("async_rst out_2", 32'(out_2), 32'd0);
        check("async_rst end_2", 32'(end_2), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_out = 1'b0;

        // Busy robustness: start toggle and input change at cycle 10 are ignored.
        set_inputs(0);
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;          // cycle 0
        repeat (9) @(posedge clk);
        #1;
        start = 1'b0;
        set_all(32'h0);
        @(posedge clk); #1;          // cycle 10
        start = 1'b1;
        wait_done(11, lat);
        check("busy latency", lat, 34);
        check("busy out_2", 32'(out_2), 32'd1);
        last_out = 1'b1;

        // Reset at cycle 20 aborts; the next start completes normally.
        set_inputs(2);
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;          // cycle 0
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst out_2", 32'(out_2), 32'd0);
        check("mid_rst end_2", 32'(end_2), 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("after_rst idle end_2", 32'(end_2), 32'd0);
        last_out = 1'b0;
        run_vec(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
